// File: rtl/mvu_job_agu.sv
// MVU job controller / address generator: snapshots the hart's job CSRs on start,
// walks a 4-level nested loop emitting W/I/O addresses, then returns an irq pulse.
module mvu_job_agu #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mvu_start,
  input  logic [31:0]       csr_mvu_wbaseaddr,
  input  logic [31:0]       csr_mvu_ibaseaddr,
  input  logic [31:0]       csr_mvu_obaseaddr,
  input  logic [31:0]       csr_mvu_wstride_0,
  input  logic [31:0]       csr_mvu_wstride_1,
  input  logic [31:0]       csr_mvu_wstride_2,
  input  logic [31:0]       csr_mvu_wstride_3,
  input  logic [31:0]       csr_mvu_istride_0,
  input  logic [31:0]       csr_mvu_istride_1,
  input  logic [31:0]       csr_mvu_istride_2,
  input  logic [31:0]       csr_mvu_istride_3,
  input  logic [31:0]       csr_mvu_ostride_0,
  input  logic [31:0]       csr_mvu_ostride_1,
  input  logic [31:0]       csr_mvu_ostride_2,
  input  logic [31:0]       csr_mvu_ostride_3,
  input  logic [31:0]       csr_mvu_wlength_0,
  input  logic [31:0]       csr_mvu_wlength_1,
  input  logic [31:0]       csr_mvu_wlength_2,
  input  logic [31:0]       csr_mvu_wlength_3,
  output logic              agu_valid,
  input  logic              agu_ready,
  output logic [ADDR_W-1:0] agu_waddr,
  output logic [ADDR_W-1:0] agu_iaddr,
  output logic [ADDR_W-1:0] agu_oaddr,
  output logic              agu_last,
  output logic              mvu_irq_o,
  output logic [31:0]       csr_mvu_status
);

  localparam int unsigned NLVL = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_e;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [LEN_W-1:0]  len_t;

  state_e             state_q, state_d;
  addr_t              wbase_q, wbase_d, ibase_q, ibase_d, obase_q, obase_d;
  addr_t [NLVL-1:0]   wstr_q, wstr_d, istr_q, istr_d, ostr_q, ostr_d;
  len_t  [NLVL-1:0]   len_q, len_d, cnt_q, cnt_d;
  addr_t              wacc_q, wacc_d, iacc_q, iacc_d, oacc_q, oacc_d;
  logic               done_q, done_d, err_q, err_d;

  len_t  [NLVL-1:0]   cnt_step;
  addr_t              wacc_step, iacc_step, oacc_step;
  logic               carry;
  logic               at_end;
  logic               unused_csr_hi;

  // Upper CSR bits beyond the address/length widths carry no meaning here.
  assign unused_csr_hi = ^{csr_mvu_wbaseaddr[31:ADDR_W], csr_mvu_ibaseaddr[31:ADDR_W],
                           csr_mvu_obaseaddr[31:ADDR_W],
                           csr_mvu_wstride_0[31:ADDR_W], csr_mvu_wstride_1[31:ADDR_W],
                           csr_mvu_wstride_2[31:ADDR_W], csr_mvu_wstride_3[31:ADDR_W],
                           csr_mvu_istride_0[31:ADDR_W], csr_mvu_istride_1[31:ADDR_W],
                           csr_mvu_istride_2[31:ADDR_W], csr_mvu_istride_3[31:ADDR_W],
                           csr_mvu_ostride_0[31:ADDR_W], csr_mvu_ostride_1[31:ADDR_W],
                           csr_mvu_ostride_2[31:ADDR_W], csr_mvu_ostride_3[31:ADDR_W],
                           csr_mvu_wlength_0[31:LEN_W], csr_mvu_wlength_1[31:LEN_W],
                           csr_mvu_wlength_2[31:LEN_W], csr_mvu_wlength_3[31:LEN_W]};

  // Odometer step: the lowest level not yet at its bound advances, lower ones clear.
  always_comb begin
    cnt_step  = cnt_q;
    wacc_step = wacc_q;
    iacc_step = iacc_q;
    oacc_step = oacc_q;
    carry     = 1'b1;
    at_end    = 1'b1;
    for (int k = 0; k < NLVL; k++) begin
      if (cnt_q[k] != len_q[k]) at_end = 1'b0;
      if (carry) begin
        if (cnt_q[k] < len_q[k]) begin
          cnt_step[k] = cnt_q[k] + LEN_W'(1);
          wacc_step   = wacc_q + wstr_q[k];
          iacc_step   = iacc_q + istr_q[k];
          oacc_step   = oacc_q + ostr_q[k];
          carry       = 1'b0;
        end else begin
          cnt_step[k] = '0;
        end
      end
    end
  end

  // Next-state and job control.
  always_comb begin
    state_d = state_q;
    wbase_d = wbase_q;
    ibase_d = ibase_q;
    obase_d = obase_q;
    wstr_d  = wstr_q;
    istr_d  = istr_q;
    ostr_d  = ostr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wacc_d  = wacc_q;
    iacc_d  = iacc_q;
    oacc_d  = oacc_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mvu_start) begin
          wbase_d = ADDR_W'(csr_mvu_wbaseaddr);
          ibase_d = ADDR_W'(csr_mvu_ibaseaddr);
          obase_d = ADDR_W'(csr_mvu_obaseaddr);
          wstr_d  = {ADDR_W'(csr_mvu_wstride_3), ADDR_W'(csr_mvu_wstride_2),
                     ADDR_W'(csr_mvu_wstride_1), ADDR_W'(csr_mvu_wstride_0)};
          istr_d  = {ADDR_W'(csr_mvu_istride_3), ADDR_W'(csr_mvu_istride_2),
                     ADDR_W'(csr_mvu_istride_1), ADDR_W'(csr_mvu_istride_0)};
          ostr_d  = {ADDR_W'(csr_mvu_ostride_3), ADDR_W'(csr_mvu_ostride_2),
                     ADDR_W'(csr_mvu_ostride_1), ADDR_W'(csr_mvu_ostride_0)};
          len_d   = {LEN_W'(csr_mvu_wlength_3), LEN_W'(csr_mvu_wlength_2),
                     LEN_W'(csr_mvu_wlength_1), LEN_W'(csr_mvu_wlength_0)};
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        wacc_d  = wbase_q;
        iacc_d  = ibase_q;
        oacc_d  = obase_q;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (agu_ready) begin
          if (at_end) begin
            state_d = ST_DONE;
          end else begin
            cnt_d  = cnt_step;
            wacc_d = wacc_step;
            iacc_d = iacc_step;
            oacc_d = oacc_step;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (mvu_start && (state_q != ST_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wbase_q <= '0;
      ibase_q <= '0;
      obase_q <= '0;
      wstr_q  <= '0;
      istr_q  <= '0;
      ostr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wacc_q  <= '0;
      iacc_q  <= '0;
      oacc_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wbase_q <= wbase_d;
      ibase_q <= ibase_d;
      obase_q <= obase_d;
      wstr_q  <= wstr_d;
      istr_q  <= istr_d;
      ostr_q  <= ostr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wacc_q  <= wacc_d;
      iacc_q  <= iacc_d;
      oacc_q  <= oacc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign agu_valid      = (state_q == ST_RUN);
  assign agu_last       = agu_valid & at_end;
  assign agu_waddr      = wacc_q;
  assign agu_iaddr      = iacc_q;
  assign agu_oaddr      = oacc_q;
  assign mvu_irq_o      = (state_q == ST_DONE);
  assign csr_mvu_status = {29'd0, err_q, done_q, (state_q != ST_IDLE)};

endmodule

// File: tb/tb_mvu_job_agu.sv
// Scoreboard bench for mvu_job_agu: a loop model queues expected beats at job start,
// a negedge monitor pops and compares them on each handshake.
module tb_mvu_job_agu;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned LEN_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] w;
    logic [ADDR_W-1:0] i;
    logic [ADDR_W-1:0] o;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              mvu_start;
  logic [31:0]       wbase, ibase, obase;
  logic [31:0]       wstr [4];
  logic [31:0]       istr [4];
  logic [31:0]       ostr [4];
  logic [31:0]       wlen [4];
  logic              agu_valid, agu_ready, agu_last, mvu_irq_o;
  logic [ADDR_W-1:0] agu_waddr, agu_iaddr, agu_oaddr;
  logic [31:0]       csr_mvu_status;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    beat_cnt = 0;
  int    irq_cnt  = 0;
  int    beat0, irq0;
  bit    rand_ready = 1'b0;
  bit    stall_pend = 1'b0;
  bit    hs_last_prev = 1'b0;
  beat_t held;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mvu_job_agu #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .mvu_start(mvu_start),
    .csr_mvu_wbaseaddr(wbase), .csr_mvu_ibaseaddr(ibase), .csr_mvu_obaseaddr(obase),
    .csr_mvu_wstride_0(wstr[0]), .csr_mvu_wstride_1(wstr[1]),
    .csr_mvu_wstride_2(wstr[2]), .csr_mvu_wstride_3(wstr[3]),
    .csr_mvu_istride_0(istr[0]), .csr_mvu_istride_1(istr[1]),
    .csr_mvu_istride_2(istr[2]), .csr_mvu_istride_3(istr[3]),
    .csr_mvu_ostride_0(ostr[0]), .csr_mvu_ostride_1(ostr[1]),
    .csr_mvu_ostride_2(ostr[2]), .csr_mvu_ostride_3(ostr[3]),
    .csr_mvu_wlength_0(wlen[0]), .csr_mvu_wlength_1(wlen[1]),
    .csr_mvu_wlength_2(wlen[2]), .csr_mvu_wlength_3(wlen[3]),
    .agu_valid(agu_valid), .agu_ready(agu_ready),
    .agu_waddr(agu_waddr), .agu_iaddr(agu_iaddr), .agu_oaddr(agu_oaddr),
    .agu_last(agu_last), .mvu_irq_o(mvu_irq_o), .csr_mvu_status(csr_mvu_status)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ready stimulus, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    agu_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Handshake monitor: scoreboard compare, stall stability, irq timing.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend   = 1'b0;
      hs_last_prev = 1'b0;
    end else begin
      if (hs_last_prev) check_eq("valid_after_last", 32'(agu_valid), 32'd0);
      if (mvu_irq_o) begin
        irq_cnt++;
        check_eq("irq_timing", 32'(hs_last_prev), 32'd1);
      end
      if (stall_pend) begin
        check_eq("stall_valid", 32'(agu_valid), 32'd1);
        check_eq("stall_beat", 32'({agu_waddr, agu_iaddr, agu_oaddr, agu_last} == held), 32'd1);
      end
      if (agu_valid && agu_ready) begin
        beat_t e;
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("waddr", 32'(agu_waddr), 32'(e.w));
          check_eq("iaddr", 32'(agu_iaddr), 32'(e.i));
          check_eq("oaddr", 32'(agu_oaddr), 32'(e.o));
          check_eq("last",  32'(agu_last),  32'(e.last));
        end
        hs_last_prev = agu_last;
      end else begin
        hs_last_prev = 1'b0;
      end
      stall_pend = agu_valid && !agu_ready;
      held       = {agu_waddr, agu_iaddr, agu_oaddr, agu_last};
    end
  end

  // Reference walk: beat addresses follow the level whose index just advanced.
  task automatic push_expected();
    logic [ADDR_W-1:0] w, i, o;
    int l0, l1, l2, l3, lvl;
    bit first;
    l0 = int'(wlen[0][LEN_W-1:0]);
    l1 = int'(wlen[1][LEN_W-1:0]);
    l2 = int'(wlen[2][LEN_W-1:0]);
    l3 = int'(wlen[3][LEN_W-1:0]);
    w = wbase[ADDR_W-1:0];
    i = ibase[ADDR_W-1:0];
    o = obase[ADDR_W-1:0];
    first = 1'b1;
    for (int c3 = 0; c3 <= l3; c3++)
      for (int c2 = 0; c2 <= l2; c2++)
        for (int c1 = 0; c1 <= l1; c1++)
          for (int c0 = 0; c0 <= l0; c0++) begin
            if (!first) begin
              lvl = (c0 != 0) ? 0 : (c1 != 0) ? 1 : (c2 != 0) ? 2 : 3;
              w = w + wstr[lvl][ADDR_W-1:0];
              i = i + istr[lvl][ADDR_W-1:0];
              o = o + ostr[lvl][ADDR_W-1:0];
            end
            first = 1'b0;
            exp_q.push_back('{w: w, i: i, o: o,
                              last: (c0 == l0) && (c1 == l1) && (c2 == l2) && (c3 == l3)});
          end
  endtask

  task automatic clear_cfg();
    wbase = '0; ibase = '0; obase = '0;
    for (int k = 0; k < 4; k++) begin
      wstr[k] = '0; istr[k] = '0; ostr[k] = '0; wlen[k] = '0;
    end
  endtask

  task automatic start_job();
    beat0 = beat_cnt;
    irq0  = irq_cnt;
    push_expected();
    @(posedge clk); #1 mvu_start = 1'b1;
    @(posedge clk); #1 mvu_start = 1'b0;
    @(negedge clk);
    check_eq("load_valid", 32'(agu_valid), 32'd0);
    check_eq("load_status", csr_mvu_status, 32'h1);
    @(negedge clk);
    check_eq("first_valid", 32'(agu_valid), 32'd1);
  endtask

  task automatic wait_done(input int nbeats, input logic [31:0] st);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (mvu_irq_o) seen = 1'b1;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check_eq("status_after", csr_mvu_status, st);
    check_eq("irq_width", 32'(mvu_irq_o), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("irq_count", 32'(irq_cnt - irq0), 32'd1);
    check_eq("beat_count", 32'(beat_cnt - beat0), 32'(nbeats));
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mvu_start = 1'b0;
    agu_ready = 1'b1;
    clear_cfg();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(agu_valid), 32'd0);
    check_eq("rst_status", csr_mvu_status, 32'd0);
    check_eq("rst_irq", 32'(mvu_irq_o), 32'd0);
    check_eq("rst_addr", 32'({agu_waddr, agu_iaddr, agu_oaddr, agu_last}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single-beat job.
    clear_cfg();
    wbase = 32'h10; ibase = 32'h20; obase = 32'h30;
    start_job();
    check_eq("job1_status_run", csr_mvu_status, 32'h1);
    wait_done(1, 32'h2);

    // Level-0 only, stride 2.
    clear_cfg();
    wbase = 32'h100; wstr[0] = 32'd2; wlen[0] = 32'd3;
    start_job();
    wait_done(4, 32'h2);

    // Two levels with a negative outer W stride.
    clear_cfg();
    wlen[0] = 32'd1; wlen[1] = 32'd2;
    wstr[0] = 32'd1; wstr[1] = 32'hFFFF_FFFF;
    istr[0] = 32'd4; istr[1] = 32'd4;
    start_job();
    wait_done(6, 32'h2);

    // Same job under random back-pressure.
    rand_ready = 1'b1;
    start_job();
    wait_done(6, 32'h2);
    rand_ready = 1'b0;

    // Address wrap at 2^ADDR_W.
    clear_cfg();
    wbase = 32'h7FFF; wstr[0] = 32'd1; wlen[0] = 32'd1;
    start_job();
    wait_done(2, 32'h2);

    // Start mid-run is flagged and ignored; CSR changes mid-job are not sampled.
    clear_cfg();
    wlen[0] = 32'd1; wlen[1] = 32'd2;
    wstr[0] = 32'd1; wstr[1] = 32'hFFFF_FFFF;
    istr[0] = 32'd4; istr[1] = 32'd4; ostr[2] = 32'd9; wlen[2] = 32'd1;
    start_job();
    @(posedge clk); #1 mvu_start = 1'b1; wbase = 32'h55; wstr[0] = 32'd7;
    @(posedge clk); #1 mvu_start = 1'b0;
    @(negedge clk);
    check_eq("start_err_status", csr_mvu_status, 32'h5);
    wait_done(12, 32'h6);

    // Reset during beat 2 of a 4-beat job aborts it silently.
    clear_cfg();
    wbase = 32'h40; wstr[0] = 32'd1; wlen[0] = 32'd3;
    start_job();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_valid", 32'(agu_valid), 32'd0);
    check_eq("abort_status", csr_mvu_status, 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    check_eq("abort_no_irq", 32'(irq_cnt - irq0), 32'd0);
    start_job();
    wait_done(4, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
